// File: rtl/cache_control_pkg.sv
// rtl/cache_control_pkg.sv - shared state encoding and widths for the cache controller
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state;

  localparam int CNT_W = 16;

endpackage

// File: rtl/cache_control_perf_counter.sv
// rtl/cache_control_perf_counter.sv - wrapping hit/miss event counters for the cache controller
module cache_perf_counter
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_hit,
  input  logic             i_miss,
  output logic [CNT_W-1:0] o_hit_count,
  output logic [CNT_W-1:0] o_miss_count
);

  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (i_hit)  r_hit_count  <= r_hit_count + 1'b1;
      if (i_miss) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - two-way write-back cache FSM (IDLE/WRITEBACK/ALLOCATE)
// Optional hit/miss counters are enabled with the CACHE_PERF_CNT_EN macro.
module cache_control
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             lru,
  output logic             load0,
  output logic             load1,
  output logic             load_data_valid_dirty,
  output logic             load_tag,
  output logic             load_lru,
  output logic             lru_in,
  output logic             dirty_in,
  output logic             data_in_sel,
  output logic             pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
`ifdef CACHE_PERF_CNT_EN
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
`endif
  input  logic             pmem_resp
);

  lc3b_cache_state r_state;
  lc3b_cache_state w_next;
  logic            r_victim;
  logic            w_req;
  logic            w_hit;
  logic            w_miss_evt;
  logic            w_hit_evt;

  assign w_req = mem_read | mem_write;
  assign w_hit = hit0 | hit1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_next;
      // Victim is frozen at miss time so lru churn mid-miss cannot redirect the fill.
      if (w_miss_evt) r_victim <= lru;
    end
  end

  always_comb begin
    w_next                = r_state;
    w_hit_evt             = 1'b0;
    w_miss_evt            = 1'b0;
    mem_resp              = 1'b0;
    load0                 = 1'b0;
    load1                 = 1'b0;
    load_data_valid_dirty = 1'b0;
    load_tag              = 1'b0;
    load_lru              = 1'b0;
    lru_in                = 1'b0;
    dirty_in              = 1'b0;
    data_in_sel           = 1'b0;
    pmem_addr_sel         = 1'b0;
    pmem_read             = 1'b0;
    pmem_write            = 1'b0;
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            w_hit_evt = 1'b1;
            mem_resp  = 1'b1;
            load_lru  = 1'b1;
            lru_in    = hit0;
            // A simultaneous read and write is serviced as a write.
            if (mem_write) begin
              load0                 = hit0;
              load1                 = hit1 & ~hit0;
              load_data_valid_dirty = 1'b1;
              dirty_in              = 1'b1;
            end
          end else if (w_req) begin
            w_miss_evt = 1'b1;
            w_next     = (lru ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) w_next = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load0                 = ~r_victim;
            load1                 = r_victim;
            load_data_valid_dirty = 1'b1;
            load_tag              = 1'b1;
            data_in_sel           = 1'b1;
            w_next                = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic r_after_fill;

  // The hit that completes a miss is already accounted for by miss_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_after_fill <= 1'b0;
    else       r_after_fill <= (r_state == ALLOCATE) && pmem_resp;
  end

  cache_perf_counter u_perf (
    .clk          (clk),
    .reset        (reset),
    .i_hit        (w_hit_evt & ~r_after_fill),
    .i_miss       (w_miss_evt),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
  );
`else
  logic w_unused;
  assign w_unused = w_hit_evt;
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed vector bench for cache_control (CACHE_PERF_CNT_EN adds counter checks)
module tb_cache_control;

  logic clk = 1'b0;
  logic reset;
  logic mem_read, mem_write, mem_resp;
  logic hit0, hit1, dirty0, dirty1, lru;
  logic load0, load1, load_data_valid_dirty, load_tag, load_lru, lru_in;
  logic dirty_in, data_in_sel, pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
  int exp_hits;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
    .load0(load0), .load1(load1), .load_data_valid_dirty(load_data_valid_dirty),
    .load_tag(load_tag), .load_lru(load_lru), .lru_in(lru_in),
    .dirty_in(dirty_in), .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
`ifdef CACHE_PERF_CNT_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .pmem_resp(pmem_resp)
  );

  // {mem_resp, load0, load1, ldvd, load_tag, load_lru, lru_in, dirty_in, data_in_sel, pmem_addr_sel, pmem_read, pmem_write}
  function automatic logic [11:0] outs();
    return {mem_resp, load0, load1, load_data_valid_dirty, load_tag, load_lru,
            lru_in, dirty_in, data_in_sel, pmem_addr_sel, pmem_read, pmem_write};
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  in;   // {mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru}
    logic [11:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{"idle_noreq",   7'b0000000, 12'h000};
    vt[1] = '{"rd_hit1_lru1", 7'b1001001, 12'h840};
    vt[2] = '{"rd_hit0",      7'b1010000, 12'h860};
    vt[3] = '{"wr_hit0",      7'b0110000, 12'hD70};
    vt[4] = '{"wr_hit1",      7'b0101110, 12'hB50};
    vt[5] = '{"wr_both_hits", 7'b0111000, 12'hD70};
    vt[6] = '{"rdwr_hit1",    7'b1101000, 12'hB50};
    vt[7] = '{"rd_both_hits", 7'b1011000, 12'h860};
    vt[8] = '{"hit_noreq",    7'b0010001, 12'h000};

    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit0 = 1'b1; hit1 = 1'b0;
    dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 12'h000);
`ifdef CACHE_PERF_CNT_EN
    exp_hits = 0;
`endif
    tick();
    reset = 1'b0; mem_read = 1'b0; hit0 = 1'b0;

    for (int i = 0; i < 9; i++) begin
      {mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru} = vt[i].in;
      @(negedge clk);
      chk(vt[i].name, vt[i].exp);
`ifdef CACHE_PERF_CNT_EN
      if (vt[i].exp[11]) exp_hits++;
`endif
      tick();
    end

    // Clean read miss: straight to ALLOCATE, 3 wait cycles, fill way 0, then hit.
    mem_read = 1'b1; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    lru = 1'b0; dirty0 = 1'b0; dirty1 = 1'b1;
    @(negedge clk); chk("a_idle_miss", 12'h000);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("a_alloc_wait", 12'h002);
      tick();
    end
    pmem_resp = 1'b1;
    @(negedge clk); chk("a_fill_way0", 12'h58A);
    tick();
    pmem_resp = 1'b0; hit0 = 1'b1;
    @(negedge clk); chk("a_post_fill_hit", 12'h860);
    tick();
    mem_read = 1'b0; hit0 = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    chk16("a_hit_count", hit_count, exp_hits[15:0]);
    chk16("a_miss_count", miss_count, 16'd1);
`endif

    // Dirty write miss on way 1; lru flips mid-miss and must not move the fill.
    mem_write = 1'b1; lru = 1'b1; dirty0 = 1'b0; dirty1 = 1'b1;
    @(negedge clk); chk("b_idle_miss", 12'h000);
    tick();
    lru = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("b_writeback", 12'h005);
      tick();
    end
    pmem_resp = 1'b1;
    @(negedge clk); chk("b_wb_resp", 12'h005);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk); chk("b_alloc_wait", 12'h002);
    tick();
    pmem_resp = 1'b1;
    @(negedge clk); chk("b_fill_way1", 12'h38A);
    tick();
    pmem_resp = 1'b0; hit1 = 1'b1;
    @(negedge clk); chk("b_post_fill_wr_hit1", 12'hB50);
    tick();
    mem_write = 1'b0; hit1 = 1'b0;

    // Request dropped mid-miss: fill still completes, then quiet IDLE.
    mem_read = 1'b1; lru = 1'b0; dirty0 = 1'b0;
    tick();
    mem_read = 1'b0;
    @(negedge clk); chk("d_alloc_noreq", 12'h002);
    tick();
    pmem_resp = 1'b1;
    @(negedge clk); chk("d_fill_noreq", 12'h58A);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk); chk("d_idle_after", 12'h000);
    tick();
`ifdef CACHE_PERF_CNT_EN
    chk16("d_miss_count", miss_count, 16'd3);
`endif

    // Reset in ALLOCATE: strobes drop at once and no fill happens.
    mem_read = 1'b1; lru = 1'b0; dirty0 = 1'b0;
    tick();
    @(negedge clk); chk("c_alloc", 12'h002);
    #2;
    reset = 1'b1;
    #1; chk("c_reset_immediate", 12'h000);
    pmem_resp = 1'b1; hit0 = 1'b1;
    #1; chk("c_reset_no_load", 12'h000);
`ifdef CACHE_PERF_CNT_EN
    chk16("c_hit_cleared", hit_count, 16'd0);
    chk16("c_miss_cleared", miss_count, 16'd0);
`endif
    tick();
    reset = 1'b0; pmem_resp = 1'b0;
    @(negedge clk); chk("c_idle_after_reset", 12'h860);

`ifdef CACHE_PERF_CNT_EN
    repeat (65535) @(posedge clk);
    #1;
    chk16("e_hit_ffff", hit_count, 16'hFFFF);
    tick();
    chk16("e_hit_wrap", hit_count, 16'h0000);
`endif
    tick();
    mem_read = 1'b0; hit0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    if (pmem_read && pmem_write) begin
      n_bad++;
      $display("FAIL pmem_excl: got read=1 write=1 expected not both");
    end
  end

endmodule
